// File: rtl/interrupt_control_unit.sv
// Hardware interrupt sequencer: latches requests, waits for a pipeline boundary, pushes PC/CCR,
// fetches the ISR vector and redirects fetch. Define INT_NEST_BLOCK_EN to block nesting until RTI.
module interrupt_control_unit #(
  parameter int unsigned PC_W     = 32,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned VEC_ADDR = 0,
  parameter int unsigned FLAG_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              int_req,
  input  logic              stall,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [FLAG_W-1:0] ccr_in,
  input  logic              rti_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              int_flag,
  output logic [3:0]        alu_function,
  output logic              stack_operation,
  output logic              push_pop,
  output logic              write_sp,
  output logic              DMW,
  output logic              branch,
  output logic              data_read,
  output logic              data_write,
  output logic              DMR,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] push_data,
  output logic              flush,
  output logic              pc_load,
  output logic [PC_W-1:0]   pc_target,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_PUSH_PC_H, S_PUSH_PC_L, S_PUSH_FLG, S_VEC_H, S_VEC_L, S_LOAD
  } state_e;

  localparam logic [DATA_W-1:0] VEC_H_ADDR = DATA_W'(VEC_ADDR);
  localparam logic [DATA_W-1:0] VEC_L_ADDR = DATA_W'(VEC_ADDR + 1);
  localparam logic [3:0]        ALU_PUSH   = 4'b0100;

  state_e              state_q, state_d;
  logic                pending_q, pending_d;
  logic                int_req_q;
  logic [PC_W-1:0]     ret_pc_q, ret_pc_d;
  logic [FLAG_W-1:0]   ccr_q, ccr_d;
  logic [DATA_W-1:0]   vec_hi_q, vec_hi_d;
  logic [DATA_W-1:0]   vec_lo_q, vec_lo_d;
  logic                push_ctl;
  logic                start_ok;

`ifdef INT_NEST_BLOCK_EN
  logic in_service_q, in_service_d;

  // LOAD is applied after the RTI clear so a coincident RTI cannot release the new ISR.
  always_comb begin
    in_service_d = in_service_q;
    if (rti_done)          in_service_d = 1'b0;
    if (state_q == S_LOAD) in_service_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_service_q <= 1'b0;
    else        in_service_q <= in_service_d;
  end

  assign start_ok = pending_q && !in_service_q;
`else
  logic unused_rti_done;
  assign unused_rti_done = rti_done;
  assign start_ok        = pending_q;
`endif

  always_comb begin
    pending_d = pending_q;
    if (state_q == S_ARM && !stall)  pending_d = 1'b0;
    if (int_req && !int_req_q)       pending_d = 1'b1;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    ret_pc_d  = ret_pc_q;
    ccr_d     = ccr_q;
    vec_hi_d  = vec_hi_q;
    vec_lo_d  = vec_lo_q;
    push_ctl  = 1'b0;
    DMR       = 1'b0;
    mem_addr  = '0;
    push_data = '0;
    pc_load   = 1'b0;
    pc_target = {vec_hi_q, vec_lo_q};

    unique case (state_q)
      S_IDLE: if (start_ok) state_d = S_ARM;
      S_ARM: begin
        if (!stall) begin
          ret_pc_d = pc_in;
          ccr_d    = ccr_in;
          state_d  = S_PUSH_PC_H;
        end
      end
      S_PUSH_PC_H: begin
        push_ctl  = 1'b1;
        push_data = ret_pc_q[PC_W-1:DATA_W];
        state_d   = S_PUSH_PC_L;
      end
      S_PUSH_PC_L: begin
        push_ctl  = 1'b1;
        push_data = ret_pc_q[DATA_W-1:0];
        state_d   = S_PUSH_FLG;
      end
      S_PUSH_FLG: begin
        push_ctl  = 1'b1;
        push_data = DATA_W'(ccr_q);
        state_d   = S_VEC_H;
      end
      S_VEC_H: begin
        DMR      = 1'b1;
        mem_addr = VEC_H_ADDR;
        state_d  = S_VEC_L;
      end
      // Read data lags DMR by one cycle: the high half arrives here, the low half in LOAD.
      S_VEC_L: begin
        DMR      = 1'b1;
        mem_addr = VEC_L_ADDR;
        vec_hi_d = mem_rdata;
        state_d  = S_LOAD;
      end
      S_LOAD: begin
        vec_lo_d  = mem_rdata;
        pc_load   = 1'b1;
        pc_target = {vec_hi_q, mem_rdata};
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pending_q <= 1'b0;
      int_req_q <= 1'b0;
      ret_pc_q  <= '0;
      ccr_q     <= '0;
      vec_hi_q  <= '0;
      vec_lo_q  <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      int_req_q <= int_req;
      ret_pc_q  <= ret_pc_d;
      ccr_q     <= ccr_d;
      vec_hi_q  <= vec_hi_d;
      vec_lo_q  <= vec_lo_d;
    end
  end

  assign int_flag = (state_q != S_IDLE);
  assign busy     = int_flag;
  assign flush    = int_flag;

  // Shared decoder bus: released whenever the decoder owns it.
  assign alu_function    = int_flag ? (push_ctl ? ALU_PUSH : 4'b0000) : 4'bzzzz;
  assign stack_operation = int_flag ? push_ctl : 1'bz;
  assign push_pop        = int_flag ? push_ctl : 1'bz;
  assign write_sp        = int_flag ? push_ctl : 1'bz;
  assign DMW             = int_flag ? push_ctl : 1'bz;
  assign branch          = int_flag ? 1'b0 : 1'bz;
  assign data_read       = int_flag ? 1'b0 : 1'bz;
  assign data_write      = int_flag ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_interrupt_control_unit.sv
// Scoreboard bench for interrupt_control_unit: expected pushes and vector loads are queued
// when a request is driven and retired as the DUT produces them.
module tb_interrupt_control_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        int_req = 1'b0;
  logic        stall = 1'b0;
  logic        rti_done = 1'b0;
  logic [31:0] pc_in = '0;
  logic [2:0]  ccr_in = '0;
  logic [15:0] mem_rdata = '0;

  wire        int_flag, stack_operation, push_pop, write_sp, DMW;
  wire        branch, data_read, data_write, DMR, flush, pc_load, busy;
  wire [3:0]  alu_function;
  wire [15:0] mem_addr, push_data;
  wire [31:0] pc_target;

  interrupt_control_unit dut (
    .clk(clk), .rst_n(rst_n), .int_req(int_req), .stall(stall), .pc_in(pc_in),
    .ccr_in(ccr_in), .rti_done(rti_done), .mem_rdata(mem_rdata), .int_flag(int_flag),
    .alu_function(alu_function), .stack_operation(stack_operation), .push_pop(push_pop),
    .write_sp(write_sp), .DMW(DMW), .branch(branch), .data_read(data_read),
    .data_write(data_write), .DMR(DMR), .mem_addr(mem_addr), .push_data(push_data),
    .flush(flush), .pc_load(pc_load), .pc_target(pc_target), .busy(busy)
  );

  always #5 clk = ~clk;

  wire bus_z = (alu_function === 4'bzzzz) && (stack_operation === 1'bz) &&
               (push_pop === 1'bz) && (write_sp === 1'bz) && (DMW === 1'bz) &&
               (branch === 1'bz) && (data_read === 1'bz) && (data_write === 1'bz);

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Two-word vector memory; reads return one cycle after DMR.
  logic [15:0] mem [0:1];
  always @(posedge clk)
    if (DMR === 1'b1) mem_rdata <= (mem_addr < 16'd2) ? mem[mem_addr[0]] : 16'hDEAD;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic        is_load;
    logic [31:0] val;
    int unsigned at_cyc;
  } exp_t;
  exp_t sb[$];
  int   load_cnt = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (push_pop === 1'b1) begin
        check("push_ctl", {24'd0, alu_function, stack_operation, write_sp, DMW, DMR},
              {24'd0, 4'b0100, 4'b1110});
        check("push_quiet", {29'd0, branch, data_read, data_write}, 32'd0);
        if (sb.size() == 0) check("sb_empty_push", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          check("push_kind", {31'd0, e.is_load}, 32'd0);
          check("push_data", {16'd0, push_data}, e.val);
        end
      end
      if (DMR === 1'b1) check("vec_ctl", {28'd0, alu_function}, 32'd0);
      if (pc_load === 1'b1) begin
        load_cnt++;
        if (sb.size() == 0) check("sb_empty_load", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          check("load_kind", {31'd0, e.is_load}, 32'd1);
          check("pc_target", pc_target, e.val);
          check("load_cycle", cyc, e.at_cyc);
        end
      end
    end
  end

  task automatic push_seq(input logic [31:0] pc, input logic [2:0] ccr, input int unsigned ld);
    sb.push_back('{1'b0, {16'd0, pc[31:16]}, 0});
    sb.push_back('{1'b0, {16'd0, pc[15:0]}, 0});
    sb.push_back('{1'b0, {29'd0, ccr}, 0});
    sb.push_back('{1'b1, {mem[0], mem[1]}, ld});
  endtask

  // Raises int_req in the current cycle e; optionally holds stall for n ARM cycles.
  task automatic start_irq(input logic [31:0] pc, input logic [2:0] ccr, input int n,
                           output int unsigned e);
    @(posedge clk); #1;
    int_req = 1'b1;
    pc_in   = pc;
    ccr_in  = ccr;
    e       = cyc;
    push_seq(pc, ccr, e + 8 + n);
    if (n > 0) begin
      @(posedge clk); #1;
      stall = 1'b1;
      pc_in = 32'hBAD0_0000;
      for (int k = 0; k < n; k++) begin
        @(posedge clk); #1;
        pc_in = 32'hBAD0_0001 + k;
      end
      @(posedge clk); #1;
      stall = 1'b0;
      pc_in = pc;
    end
  endtask

  task automatic at_neg(input int unsigned c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic wait_loads(input int target);
    for (int i = 0; i < 60 && load_cnt < target; i++) @(negedge clk);
    check("loads_done", load_cnt, target);
  endtask

  task automatic retire();
`ifdef INT_NEST_BLOCK_EN
    @(posedge clk); #1;
    rti_done = 1'b1;
    @(posedge clk); #1;
    rti_done = 1'b0;
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned e;
    int          base;
    mem[0] = 16'h0000;
    mem[1] = 16'h0200;

    // Reset state
    #12;
    check("rst_priv", {27'd0, busy, pc_load, flush, DMR, int_flag}, 32'd0);
    check("rst_addr_data", {mem_addr, push_data}, 32'd0);
    check("rst_target", pc_target, 32'd0);
    check("rst_bus_z", {31'd0, bus_z}, 32'd1);
    @(negedge clk); rst_n = 1'b1;

    // Single pulse, no stall: latency and push order
    start_irq(32'h0000_0123, 3'b101, 0, e);
    at_neg(e + 1);
    check("pend_no_flag", {31'd0, int_flag}, 32'd0);
    int_req = 1'b0;
    at_neg(e + 2);
    check("arm_flags", {29'd0, int_flag, flush, busy}, 32'd7);
    check("arm_bus", {24'd0, alu_function, stack_operation, push_pop, write_sp, DMW},
          32'd0);
    wait_loads(1);
    @(negedge clk);
    check("post_idle", {30'd0, busy, pc_load}, 32'd0);
    check("post_bus_z", {31'd0, bus_z}, 32'd1);
    retire();

    // Stall for 3 cycles in ARM: capture uses the first non-stalled pc_in
    mem[0] = 16'h1234;
    mem[1] = 16'h5678;
    fork
      start_irq(32'hCAFE_0042, 3'b010, 3, e);
      begin
        at_neg(cyc + 4);
        check("stall_hold", {30'd0, int_flag, push_pop}, 32'd2);
      end
    join
    int_req = 1'b0;
    wait_loads(2);
    retire();

    // Second edge during VEC_H
    mem[0] = 16'h0001;
    mem[1] = 16'h8000;
    start_irq(32'h1111_2222, 3'b001, 0, e);
    @(posedge clk); #1 int_req = 1'b0;
    while (cyc < e + 6) @(posedge clk);
    #1;
    int_req = 1'b1;
    pc_in   = 32'h3333_4444;
    ccr_in  = 3'b110;
`ifdef INT_NEST_BLOCK_EN
    push_seq(32'h3333_4444, 3'b110, e + 20);
    at_neg(e + 9);
    check("nest_idle", {31'd0, busy}, 32'd0);
    at_neg(e + 11);
    check("nest_blocked", {31'd0, busy}, 32'd0);
    while (cyc < e + 12) @(posedge clk);
    #1 rti_done = 1'b1;
    @(posedge clk); #1 rti_done = 1'b0;
    at_neg(e + 13);
    check("nest_released_idle", {31'd0, busy}, 32'd0);
    at_neg(e + 14);
    check("nest_arm", {31'd0, busy}, 32'd1);
`else
    push_seq(32'h3333_4444, 3'b110, e + 16);
    at_neg(e + 9);
    check("nest_idle_gap", {31'd0, busy}, 32'd0);
    at_neg(e + 10);
    check("nest_arm", {31'd0, busy}, 32'd1);
`endif
    int_req = 1'b0;
    wait_loads(4);
    retire();

    // int_req held high for 20 cycles: one sequence only
    base = load_cnt;
    start_irq(32'h0000_0ABC, 3'b011, 0, e);
    repeat (19) @(posedge clk);
    #1 int_req = 1'b0;
    repeat (15) @(posedge clk);
    check("held_one_seq", load_cnt, base + 1);
    check("held_busy", {31'd0, busy}, 32'd0);
    retire();

    // Reset during PUSH_PC_L aborts with no load
    base = load_cnt;
    start_irq(32'h5555_6666, 3'b111, 0, e);
    while (cyc < e + 4) @(posedge clk);
    #1;
    rst_n   = 1'b0;
    int_req = 1'b0;
    #1;
    check("abort_priv", {29'd0, int_flag, busy, pc_load}, 32'd0);
    check("abort_bus_z", {31'd0, bus_z}, 32'd1);
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_no_restart", {31'd0, busy}, 32'd0);
    check("abort_no_load", load_cnt, base);

    check("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
